// File: rtl/hs_rx_fifo_pkg.sv
// rtl/hs_rx_fifo_pkg.sv - shared constants, pointer sizing and checker error causes for hs_rx_fifo
package hs_rx_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam logic RST_IN_READY  = 1'b0;
  localparam logic RST_PROTO_ERR = 1'b0;

  typedef enum logic [1:0] {
    HS_ERR_NONE        = 2'd0,
    HS_ERR_VALID_DROP  = 2'd1,
    HS_ERR_DATA_CHANGE = 2'd2
  } hs_err_e;

endpackage

// File: rtl/hs_rx_fifo_if.sv
// rtl/hs_rx_fifo_if.sv - valid/ready handshake link between a master and the hs_rx_fifo receiver
interface hs_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/hs_rx_fifo_mem.sv
// rtl/hs_rx_fifo_mem.sv - DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read
module hs_rx_fifo_mem
  import hs_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_w(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]         rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left out of reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/hs_rx_fifo.sv
// rtl/hs_rx_fifo.sv - handshake receiver with FWFT FIFO; optional checker under HS_RX_FIFO_PROTO_CHECK_EN
module hs_rx_fifo
  import hs_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  hs_rx_fifo_if.slave             hs,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_en,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic                    proto_err
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push, pop;

  always_comb begin
    push       = hs.in_valid && in_ready_q;
    pop        = rd_en && (count_q != '0);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Ready looks ahead at the next occupancy so a pop on a full cycle reopens the link one edge later.
    in_ready_d = (count_d != DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= RST_IN_READY;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  hs_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (hs.in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign hs.in_ready  = in_ready_q;
  assign rd_valid     = (count_q != '0);
  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_C);

`ifdef HS_RX_FIFO_PROTO_CHECK_EN
  logic                  prev_valid_q, prev_valid_d;
  logic                  prev_ready_q, prev_ready_d;
  logic [DATA_WIDTH-1:0] prev_data_q, prev_data_d;
  logic                  proto_err_q, proto_err_d;
  hs_err_e               err_cause;

  // A stalled transfer (valid high, ready low last cycle) must keep valid and data stable.
  always_comb begin
    err_cause = HS_ERR_NONE;
    if (prev_valid_q && !prev_ready_q) begin
      if (!hs.in_valid) begin
        err_cause = HS_ERR_VALID_DROP;
      end else if (hs.in_data != prev_data_q) begin
        err_cause = HS_ERR_DATA_CHANGE;
      end
    end
    prev_valid_d = hs.in_valid;
    prev_ready_d = in_ready_q;
    prev_data_d  = hs.in_data;
    proto_err_d  = proto_err_q || (err_cause != HS_ERR_NONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_data_q  <= '0;
      proto_err_q  <= RST_PROTO_ERR;
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_ready_q <= prev_ready_d;
      prev_data_q  <= prev_data_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = RST_PROTO_ERR;
`endif
endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb/tb_hs_rx_fifo.sv - directed self-checking bench for hs_rx_fifo (DEPTH=4, AFULL_LVL=3)
module tb_hs_rx_fifo;
  logic       clk;
  logic       rst;
  logic       rd_en;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] count;
  logic       almost_full;
  logic       proto_err;
  int         pass_cnt;
  int         total_cnt;

`ifdef HS_RX_FIFO_PROTO_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  hs_rx_fifo_if #(.DATA_WIDTH(8)) hs_bus ();

  hs_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .AFULL_LVL  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hs          (hs_bus),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_en       (rd_en),
    .count       (count),
    .almost_full (almost_full),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd_en = 1'b0; hs_bus.in_valid = 1'b0; hs_bus.in_data = 8'h00;
    repeat (3) step();
    total_cnt++;
    if (hs_bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", hs_bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", proto_err);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if (hs_bus.in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", hs_bus.in_ready);
    else pass_cnt++;
    total_cnt++;
    if ({rd_valid, count, almost_full} !== 5'b0_000_0)
      $display("FAIL release_idle got rv=%b cnt=%0d af=%b exp rv=0 cnt=0 af=0", rd_valid, count, almost_full);
    else pass_cnt++;
  endtask

  task automatic test_fill_and_drain();
    logic [7:0] words [4];
    logic [7:0] drain [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      hs_bus.in_valid = 1'b1; hs_bus.in_data = words[i];
      step();
      total_cnt++;
      if (count !== 3'(i + 1) || almost_full !== (i + 1 >= 3) || hs_bus.in_ready !== (i + 1 < 4))
        $display("FAIL fill_%0d got cnt=%0d af=%b rdy=%b exp cnt=%0d af=%b rdy=%b", i, count,
                 almost_full, hs_bus.in_ready, i + 1, (i + 1 >= 3), (i + 1 < 4));
      else pass_cnt++;
    end
    hs_bus.in_data = 8'h55;
    repeat (3) step();
    total_cnt++;
    if (count !== 3'd4 || hs_bus.in_ready !== 1'b0)
      $display("FAIL full_hold got cnt=%0d rdy=%b exp cnt=4 rdy=0", count, hs_bus.in_ready);
    else pass_cnt++;
    rd_en = 1'b1;
    total_cnt++;
    if (rd_data !== 8'h11 || rd_valid !== 1'b1)
      $display("FAIL head_full got data=%h rv=%b exp data=11 rv=1", rd_data, rd_valid);
    else pass_cnt++;
    step();
    rd_en = 1'b0;
    total_cnt++;
    if (count !== 3'd3 || hs_bus.in_ready !== 1'b1)
      $display("FAIL pop_at_full got cnt=%0d rdy=%b exp cnt=3 rdy=1", count, hs_bus.in_ready);
    else pass_cnt++;
    step();
    hs_bus.in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd4 || hs_bus.in_ready !== 1'b0)
      $display("FAIL accept_55 got cnt=%0d rdy=%b exp cnt=4 rdy=0", count, hs_bus.in_ready);
    else pass_cnt++;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== drain[i])
        $display("FAIL drain_%0d got rv=%b data=%h exp rv=1 data=%h", i, rd_valid, rd_data, drain[i]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (rd_valid !== 1'b0 || count !== 3'd0 || hs_bus.in_ready !== 1'b1)
      $display("FAIL drained got rv=%b cnt=%0d rdy=%b exp rv=0 cnt=0 rdy=1", rd_valid, count, hs_bus.in_ready);
    else pass_cnt++;
    step();
    rd_en = 1'b0;
    total_cnt++;
    if (count !== 3'd0) $display("FAIL underflow got cnt=%0d exp=0", count);
    else pass_cnt++;
  endtask

  task automatic test_stream_wrap();
    for (int i = 0; i < 10; i++) begin
      hs_bus.in_valid = 1'b1; hs_bus.in_data = 8'(i); rd_en = 1'b1;
      if (i > 0) begin
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== 8'(i - 1))
          $display("FAIL stream_data_%0d got rv=%b data=%h exp rv=1 data=%h", i, rd_valid, rd_data, 8'(i - 1));
        else pass_cnt++;
      end
      step();
      total_cnt++;
      if (count !== 3'd1) $display("FAIL stream_cnt_%0d got=%0d exp=1", i, count);
      else pass_cnt++;
    end
    hs_bus.in_valid = 1'b0;
    total_cnt++;
    if (rd_data !== 8'h09) $display("FAIL stream_last got=%h exp=09", rd_data);
    else pass_cnt++;
    step();
    rd_en = 1'b0;
    total_cnt++;
    if (count !== 3'd0 || proto_err !== 1'b0)
      $display("FAIL stream_end got cnt=%0d perr=%b exp cnt=0 perr=0", count, proto_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      hs_bus.in_valid = 1'b1; hs_bus.in_data = 8'hB1 + 8'(i);
      step();
    end
    hs_bus.in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd3) $display("FAIL mid_pre got cnt=%0d exp=3", count);
    else pass_cnt++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    total_cnt++;
    if (count !== 3'd0 || rd_valid !== 1'b0 || hs_bus.in_ready !== 1'b0)
      $display("FAIL mid_reset got cnt=%0d rv=%b rdy=%b exp cnt=0 rv=0 rdy=0", count, rd_valid, hs_bus.in_ready);
    else pass_cnt++;
    hs_bus.in_valid = 1'b1; hs_bus.in_data = 8'hA5;
    step();
    step();
    hs_bus.in_valid = 1'b0;
    total_cnt++;
    if (count !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 8'hA5)
      $display("FAIL mid_first got cnt=%0d rv=%b data=%h exp cnt=1 rv=1 data=a5", count, rd_valid, rd_data);
    else pass_cnt++;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total_cnt++;
    if (count !== 3'd0) $display("FAIL mid_pop got cnt=%0d exp=0", count);
    else pass_cnt++;
  endtask

  task automatic test_proto_check();
    for (int i = 0; i < 4; i++) begin
      hs_bus.in_valid = 1'b1; hs_bus.in_data = 8'hC1 + 8'(i);
      step();
    end
    hs_bus.in_data = 8'h66;
    step();
    step();
    total_cnt++;
    if (proto_err !== 1'b0) $display("FAIL proto_stable got=%b exp=0", proto_err);
    else pass_cnt++;
    hs_bus.in_data = 8'h67;
    step();
    total_cnt++;
    if (proto_err !== EXP_PERR) $display("FAIL proto_set got=%b exp=%b", proto_err, EXP_PERR);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if (proto_err !== EXP_PERR) $display("FAIL proto_sticky got=%b exp=%b", proto_err, EXP_PERR);
    else pass_cnt++;
    hs_bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    total_cnt++;
    if (proto_err !== 1'b0 || count !== 3'd0)
      $display("FAIL proto_clear got perr=%b cnt=%0d exp perr=0 cnt=0", proto_err, count);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_fill_and_drain();
    test_stream_wrap();
    test_reset_mid();
    test_proto_check();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/hs_rx_fifo.md
Name: hs_rx_fifo

Overview:
- Synthesizable receiving (slave) end of the team's valid/ready handshake interface.
- Accepts words from any handshake master (data/valid in, ready out) and buffers them in a DEPTH-entry circular FIFO.
- Presents buffered words to local logic through a first-word-fall-through pop port.
- Intended as the standard terminating receiver for handshake links, and as the DUT partner for the handshake master agent.

Parameters:
- DATA_WIDTH, 8, width of the handshake data bus and of rd_data.
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- AFULL_LVL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- in_data  input  DATA_WIDTH  handshake data from the master.
- in_valid  input  1  handshake valid from the master.
- in_ready  output  1  handshake ready to the master; also serves as the ack.
- rd_valid  output  1  head entry available (FWFT).
- rd_data  output  DATA_WIDTH  head entry; valid only while rd_valid=1.
- rd_en  input  1  pop the head entry; ignored when rd_valid=0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_LVL.
- proto_err  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clock edge):
  - wr_ptr, rd_ptr and count clear to 0.
  - in_ready=0, rd_valid=0, almost_full=0, proto_err=0.
  - Storage contents are not reset.
- Reset mid-operation: all buffered data is discarded; no partial transfer survives.
- in_ready is a registered output, equal to !full of the next state. It is therefore 1 on the first edge after reset release.
- Push:
  - Occurs when in_valid && in_ready at a clock edge.
  - Writes in_data to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when rd_en && rd_valid at a clock edge.
  - rd_ptr increments modulo DEPTH.
  - rd_valid = (count != 0).
  - rd_data = mem[rd_ptr], read combinationally from registered storage.
- Latency: a word pushed at edge N is visible on rd_data with rd_valid=1 after edge N, i.e. one cycle of latency.
- No bypass: the FIFO never passes data through combinationally from in_data to rd_data.
- count update:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- Full (count==DEPTH):
  - in_ready=0.
  - A pop in this cycle reasserts in_ready on the next edge.
  - No push can occur on the same edge, so there is no overflow path.
- Empty (count==0):
  - rd_valid=0 and rd_en is ignored, so underflow is impossible.
- Simultaneous push and pop at count==1:
  - The head updates to the new word after the edge.
  - rd_valid stays 1.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap naturally. Full/empty are derived from count, not from pointer compare.
- The block never drops a word whose handshake completed and never duplicates one. Output order equals accepted order.
- The master may hold in_valid high indefinitely. The receiver makes no assumption on valid timing beyond the handshake rules.

Optional Feature:
- Macro: HS_RX_FIFO_PROTO_CHECK_EN
- Defined: proto_err is set (sticky until reset) on either violation below.
  - in_valid falls while in_ready was 0 in the previous cycle, i.e. valid was withdrawn before acceptance.
  - in_data changes while in_valid=1 and in_ready=0 in the previous cycle.
  - Implementation: register previous in_valid, in_data and in_ready.
- Not defined: proto_err is tied to 0 and the comparison registers are not synthesized. The port list is identical in both builds.

Decomposition:
- Package hs_rx_pkg holds:
  - function ptr_w(depth), returning $clog2(depth).
  - localparam-style constants for the reset values.
  - typedef enum for the checker error cause (HS_ERR_NONE, HS_ERR_VALID_DROP, HS_ERR_DATA_CHANGE), exported for the scoreboard.
- One sub-module is natural: hs_rx_fifo_mem, a DEPTH x DATA_WIDTH register array with a synchronous write port and an asynchronous read port.
- Control logic stays in the top module.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release.
  - Required: in_ready=1 on the first edge after release; rd_valid=0, count=0, almost_full=0.
- Fill with no pops (DEPTH=4): push 0x11, 0x22, 0x33, 0x44 back-to-back, then hold in_valid=1 with 0x55.
  - Required: count reaches 4, in_ready=0; almost_full=1 once count=3.
  - Required: 0x55 is not accepted until the first pop.
- Drain with in_valid=0: assert rd_en continuously.
  - Required: rd_data sequence is 0x11, 0x22, 0x33, 0x44, one per cycle.
  - Required: rd_valid falls after the 4th pop; count returns to 0.
- Streaming wrap: push and pop every cycle for 10 words, 0x00..0x09.
  - Required: count stays at 1 after the first push; output order is 0x00..0x09; pointers wrap with no loss.
- Reset mid-operation: 3 words buffered, assert rst=0 for 1 cycle.
  - Required: count=0, rd_valid=0; the next pushed word 0xA5 is the first word popped.
- With HS_RX_FIFO_PROTO_CHECK_EN: hold the FIFO full, drive in_valid=1 with 0x66, then change data to 0x67 while in_ready=0.
  - Required: proto_err=1 on the next edge and it remains 1 until reset.
  - Required in the build without the macro: proto_err=0 throughout.
